if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000013, SHALL be the instruction word driven on id_instr whenever id_valid is 0.
REQ-002 Parameter CNT_W, default 16, SHALL be the width of squash_cnt.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 if_pc  input  32  SHALL be the PC of the fetched instruction.
REQ-006 if_instr  input  32  SHALL be the fetched instruction word.
REQ-007 if_valid  input  1  SHALL indicate that if_pc/if_instr are valid this cycle.
REQ-008 if_ready  output  1  SHALL indicate that the stage accepts the fetch beat this cycle; transfer = if_valid & if_ready.
REQ-009 IF_ID_flush  input  1  SHALL squash all stage contents; driven by the flush controller, may stay high for multiple cycles.
REQ-010 id_stall  input  1  SHALL indicate that decode cannot consume the current output.
REQ-011 id_pc  output  32  SHALL be the registered PC presented to decode.
REQ-012 id_instr  output  32  SHALL be the registered instruction presented to decode.
REQ-013 id_valid  output  1  SHALL qualify id_pc/id_instr; consume = id_valid & !id_stall.
REQ-014 squash_cnt  output  CNT_W  SHALL count valid instructions discarded by flush, saturating.

Function
REQ-015 The stage SHALL have states EMPTY (no valid entry), FULL (main register valid) and, when skid is enabled, SKID (main and skid both valid).
REQ-016 Accept-to-output latency SHALL be exactly 1 cycle: a beat transferred in cycle N SHALL appear with id_valid=1 in cycle N+1 when the stage was EMPTY or consumed in cycle N.
REQ-017 EMPTY -> FULL on transfer; FULL -> EMPTY on consume without transfer; FULL -> FULL on consume with simultaneous transfer (new beat replaces old, no bubble).
REQ-018 In FULL with id_stall=1 and no skid, id_pc/id_instr/id_valid SHALL hold unchanged.
REQ-019 IF_ID_flush=1 SHALL override id_stall and any transfer: next state EMPTY, id_valid=0, id_instr=NOP_INSTR, skid cleared, incoming beat discarded.
REQ-020 if_ready SHALL be 1 while IF_ID_flush=1, so fetch drains during a flush.
REQ-021 On each flush cycle squash_cnt SHALL increase by (main valid)+(skid valid)+(if_valid & if_ready), saturating at 2^CNT_W-1 with no wrap-around.
REQ-022 id_pc SHALL hold its last value when id_valid=0; id_instr SHALL be NOP_INSTR when id_valid=0.
REQ-023 A consume and a flush in the same cycle SHALL count the consumed entry as squashed only if IF_ID_flush=1 (flush wins; decode is responsible for ignoring it).

Reset
REQ-024 On rst=1, immediately and independent of clk: state EMPTY, id_valid=0, id_pc=0, id_instr=NOP_INSTR, skid empty, squash_cnt=0.
REQ-025 if_ready SHALL be 1 during and after reset.
REQ-026 Reset asserted mid-stall or mid-flush SHALL discard all entries without incrementing squash_cnt.

Configuration
REQ-027 Macro IF_ID_SKID_EN defined: a one-entry skid register SHALL exist; if_ready SHALL be registered as !(skid valid) (flush excepted); a transfer in FULL with id_stall=1 SHALL load the skid (FULL -> SKID); on the first consume in SKID the skid entry SHALL move to the main register (SKID -> FULL) and if_ready SHALL return to 1 the next cycle.
REQ-028 Macro IF_ID_SKID_EN undefined: no skid storage, SKID state absent; if_ready SHALL be combinational !(id_valid & id_stall) | IF_ID_flush.

Verification
REQ-029 Reset, then if_valid=1 with PCs 0x100,0x104,0x108 back-to-back, id_stall=0 -> id_valid=1 cycles 1..3, id_pc 0x100,0x104,0x108, no bubbles.
REQ-030 FULL with id_pc=0x200, id_stall=1 for 3 cycles, if_valid=1 PC 0x204 -> id_pc held 0x200; skid on: 0x204 taken into skid, if_ready=0 next cycle; skid off: if_ready=0 all 3 cycles; after release id_pc=0x204 next cycle.
REQ-031 SKID state (0x300 main, 0x304 skid) plus IF_ID_flush=1 for 2 cycles with if_valid=1 each -> id_valid=0, id_instr=0x00000013, squash_cnt +3 first cycle, +1 second.
REQ-032 IF_ID_flush=1 and id_stall=1 together in FULL -> id_valid=0 next cycle, if_ready=1.
REQ-033 CNT_W=2, five single-entry flushes -> squash_cnt 1,2,3,3,3.
REQ-034 rst pulsed asynchronously between clock edges in FULL -> id_valid drops immediately, squash_cnt=0, id_instr=0x00000013.

Source files
------------

// File: rtl/if_id_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage_if
// Brief    : Fetch-side, decode-side and flush signals of the IF/ID stage.
// Revision : 1.0
// ============================================================================
interface if_id_stage_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      if_pc;
    logic [31:0]      if_instr;
    logic             if_valid;
    logic             if_ready;
    logic             IF_ID_flush;
    logic             id_stall;
    logic [31:0]      id_pc;
    logic [31:0]      id_instr;
    logic             id_valid;
    logic [CNT_W-1:0] squash_cnt;

    // Environment side: fetch, decode and flush controller together
    modport master (
        output if_pc, if_instr, if_valid, IF_ID_flush, id_stall,
        input  if_ready, id_pc, id_instr, id_valid, squash_cnt
    );

    modport slave (
        input  if_pc, if_instr, if_valid, IF_ID_flush, id_stall,
        output if_ready, id_pc, id_instr, id_valid, squash_cnt
    );
endinterface
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage
// Brief    : IF/ID pipeline register with flush, squash counter and an
//            optional one-entry skid buffer (enabled by macro IF_ID_SKID_EN).
// Revision : 1.0
// ============================================================================
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int unsigned CNT_W     = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    if_id_stage_if.slave  bus
);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_FULL  = 2'd1;
`ifdef IF_ID_SKID_EN
    localparam logic [1:0] c_ST_SKID  = 2'd2;
`endif
    localparam logic [CNT_W+1:0] c_CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [31:0]      r_main_pc;
    logic [31:0]      r_main_instr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_main_vld;
    logic             w_skid_vld;
    logic             w_if_ready;
    logic             w_xfer;
    logic             w_consume;
    logic             w_load_main_if;
    logic [1:0]       w_squash_inc;
    logic [CNT_W+1:0] w_cnt_sum;
    logic [CNT_W-1:0] w_cnt_sat;

`ifdef IF_ID_SKID_EN
    logic [31:0]      r_skid_pc;
    logic [31:0]      r_skid_instr;
    logic             r_if_ready;
    logic             w_load_skid;
    logic             w_load_main_skid;
`endif

    assign w_main_vld = (r_state != c_ST_EMPTY);
`ifdef IF_ID_SKID_EN
    assign w_skid_vld = (r_state == c_ST_SKID);
`else
    assign w_skid_vld = 1'b0;
`endif

    assign w_xfer    = bus.if_valid & w_if_ready;
    assign w_consume = w_main_vld & ~bus.id_stall;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and register-load decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_if   = 1'b0;
`ifdef IF_ID_SKID_EN
        w_load_skid      = 1'b0;
        w_load_main_skid = 1'b0;
`endif
        if (bus.IF_ID_flush) begin
            w_state_nxt = c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_xfer) begin
                        w_state_nxt    = c_ST_FULL;
                        w_load_main_if = 1'b1;
                    end
                end
                c_ST_FULL: begin
                    if (w_consume) begin
                        // A simultaneous transfer replaces the entry without a bubble
                        if (w_xfer) begin
                            w_load_main_if = 1'b1;
                        end else begin
                            w_state_nxt = c_ST_EMPTY;
                        end
                    end
`ifdef IF_ID_SKID_EN
                    else if (w_xfer) begin
                        w_state_nxt = c_ST_SKID;
                        w_load_skid = 1'b1;
                    end
`endif
                end
`ifdef IF_ID_SKID_EN
                c_ST_SKID: begin
                    if (w_consume) begin
                        w_state_nxt      = c_ST_FULL;
                        w_load_main_skid = 1'b1;
                    end
                end
`endif
                default: begin
                    w_state_nxt = c_ST_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        bus.id_valid = w_main_vld;
        bus.id_instr = w_main_vld ? r_main_instr : NOP_INSTR;
`ifdef IF_ID_SKID_EN
        w_if_ready   = r_if_ready | bus.IF_ID_flush;
`else
        w_if_ready   = ~(w_main_vld & bus.id_stall) | bus.IF_ID_flush;
`endif
        bus.if_ready = w_if_ready;
    end

    assign bus.id_pc      = r_main_pc;
    assign bus.squash_cnt = r_cnt;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_pc    <= 32'd0;
            r_main_instr <= NOP_INSTR;
        end else if (w_load_main_if) begin
            r_main_pc    <= bus.if_pc;
            r_main_instr <= bus.if_instr;
        end
`ifdef IF_ID_SKID_EN
        else if (w_load_main_skid) begin
            r_main_pc    <= r_skid_pc;
            r_main_instr <= r_skid_instr;
        end
`endif
    end

`ifdef IF_ID_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_pc    <= 32'd0;
            r_skid_instr <= NOP_INSTR;
            r_if_ready   <= 1'b1;
        end else begin
            if (w_load_skid) begin
                r_skid_pc    <= bus.if_pc;
                r_skid_instr <= bus.if_instr;
            end
            // Back-pressure is taken from the registered skid occupancy
            r_if_ready <= (w_state_nxt != c_ST_SKID);
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Saturating squash counter
    // ------------------------------------------------------------------------
    assign w_squash_inc = {1'b0, w_main_vld} + {1'b0, w_skid_vld} + {1'b0, w_xfer};
    assign w_cnt_sum    = {2'b00, r_cnt} + {{CNT_W{1'b0}}, w_squash_inc};
    assign w_cnt_sat    = (w_cnt_sum > c_CNT_MAX) ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (bus.IF_ID_flush) begin
            r_cnt <= w_cnt_sat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_stage
// Brief    : Directed bench for if_id_stage with a decode-side scoreboard.
// Revision : 1.0
// ============================================================================
module tb_if_id_stage;

`ifdef IF_ID_SKID_EN
    localparam bit SKID_ON = 1'b1;
`else
    localparam bit SKID_ON = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk;
    logic rst;

    if_id_stage_if #(.CNT_W(16)) bus  ();
    if_id_stage_if #(.CNT_W(2))  bus2 ();

    if_id_stage #(.NOP_INSTR(NOP), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    if_id_stage #(.NOP_INSTR(NOP), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int checks = 0;
    int errors = 0;
    int exp_sq = 0;
    int exp2   = 0;
    logic [63:0] sb_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {pc[15:0], 16'h0093};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic st, input logic fl);
        bus.if_valid    = v;
        bus.if_pc       = pc;
        bus.if_instr    = mk_instr(pc);
        bus.id_stall    = st;
        bus.IF_ID_flush = fl;
    endtask

    task automatic push(input logic [31:0] pc);
        sb_q.push_back({pc, mk_instr(pc)});
    endtask

    // Decode-side monitor: every consumed entry must match the next expected beat
    always @(negedge clk) begin
        if (!rst && bus.id_valid && !bus.id_stall && !bus.IF_ID_flush) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h, expected no entry", bus.id_pc);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("sb_pc", bus.id_pc, e[63:32]);
                check("sb_instr", bus.id_instr, e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        bus2.if_valid = 1'b0; bus2.if_pc = 32'd0; bus2.if_instr = 32'd0;
        bus2.id_stall = 1'b0; bus2.IF_ID_flush = 1'b0;
        #2;
        check("rst_valid", bus.id_valid, 0);
        check("rst_pc", bus.id_pc, 0);
        check("rst_instr", bus.id_instr, NOP);
        check("rst_cnt", bus.squash_cnt, 0);
        check("rst_ready", bus.if_ready, 1);
        cyc();
        rst = 1'b0;

        // Back-to-back fetch with no stall
        for (int i = 0; i < 4; i++) begin
            logic [31:0] pc;
            pc = 32'h100 + 32'(4 * i);
            if (i < 3) begin
                drive(1'b1, pc, 1'b0, 1'b0);
                push(pc);
            end else begin
                drive(1'b0, 32'd0, 1'b0, 1'b0);
            end
            neg();
            if (i > 0) begin
                check("b2b_valid", bus.id_valid, 1);
                check("b2b_pc", bus.id_pc, pc - 32'd4);
            end
            cyc();
        end
        neg();
        check("b2b_empty", bus.id_valid, 0);
        check("b2b_nop", bus.id_instr, NOP);
        check("b2b_hold_pc", bus.id_pc, 32'h108);
        cyc();

        // Stall with a pending fetch beat
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        push(32'h200);
        cyc();
        drive(1'b1, 32'h204, 1'b1, 1'b0);
        push(32'h204);
        neg();
        check("stall_pc0", bus.id_pc, 32'h200);
        check("stall_rdy0", bus.if_ready, SKID_ON);
        cyc();
        for (int i = 1; i < 3; i++) begin
            drive(!SKID_ON, 32'h204, 1'b1, 1'b0);
            neg();
            check("stall_pc", bus.id_pc, 32'h200);
            check("stall_valid", bus.id_valid, 1);
            check("stall_rdy", bus.if_ready, 0);
            cyc();
        end
        drive(!SKID_ON, 32'h204, 1'b0, 1'b0);
        neg();
        check("release_pc", bus.id_pc, 32'h200);
        cyc();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        neg();
        check("after_pc", bus.id_pc, 32'h204);
        check("after_valid", bus.id_valid, 1);
        check("after_rdy", bus.if_ready, 1);
        cyc();

        // Flush over a full (or skid) stage for two cycles
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h304, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 32'h308, 1'b1, 1'b1);
        neg();
        check("flush_rdy", bus.if_ready, 1);
        cyc();
        exp_sq += SKID_ON ? 3 : 2;
        drive(1'b1, 32'h30C, 1'b1, 1'b1);
        neg();
        check("flush_valid", bus.id_valid, 0);
        check("flush_instr", bus.id_instr, NOP);
        check("flush_cnt1", bus.squash_cnt, 32'(exp_sq));
        cyc();
        exp_sq += 1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        neg();
        check("flush_cnt2", bus.squash_cnt, 32'(exp_sq));
        check("flush_valid2", bus.id_valid, 0);
        cyc();

        // Flush and stall together
        drive(1'b1, 32'h400, 1'b1, 1'b0);
        cyc();
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        neg();
        check("fs_rdy", bus.if_ready, 1);
        cyc();
        exp_sq += 1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        neg();
        check("fs_valid", bus.id_valid, 0);
        check("fs_rdy2", bus.if_ready, 1);
        check("fs_cnt", bus.squash_cnt, 32'(exp_sq));
        cyc();

        // Asynchronous reset between edges while FULL
        drive(1'b1, 32'h500, 1'b1, 1'b0);
        cyc();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", bus.id_valid, 0);
        check("arst_instr", bus.id_instr, NOP);
        check("arst_cnt", bus.squash_cnt, 0);
        check("arst_pc", bus.id_pc, 0);
        check("arst_rdy", bus.if_ready, 1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        exp_sq = 0;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        cyc();
        neg();
        check("arst_cnt_after", bus.squash_cnt, 32'(exp_sq));
        cyc();

        // Saturation with a 2-bit counter
        for (int k = 1; k <= 5; k++) begin
            bus2.if_valid = 1'b1;
            bus2.if_pc    = 32'h600 + 32'(4 * k);
            bus2.if_instr = mk_instr(bus2.if_pc);
            bus2.id_stall = 1'b1;
            cyc();
            bus2.if_valid    = 1'b0;
            bus2.IF_ID_flush = 1'b1;
            cyc();
            bus2.IF_ID_flush = 1'b0;
            bus2.id_stall    = 1'b0;
            exp2 = (exp2 < 3) ? exp2 + 1 : 3;
            neg();
            check("sat_cnt", 32'(bus2.squash_cnt), 32'(exp2));
            cyc();
        end

        check("sb_drain", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
